mio_bus_responder: RTL
======================

Name: mio_bus_responder

Overview:
- Target-side bus controller for the multi-cycle CPU's memory/IO bus.
- Accepts CPU requests (breq, mem_w, address, write data) and decodes the address to one of three targets: block RAM, LED/switch port, or a 32-bit counter.
- Inserts per-region wait states, then returns read data with a one-cycle MIO_ready pulse.
- Sits between the CPU's bus outputs and the RAM/peripherals at SoC top level.

Parameters:
- RAM_ADDR_W, 10, word-address width of the RAM port; must be at most 26.
- RAM_WAIT, 1, wait cycles for a RAM access; minimum 1 because the RAM has 1-cycle read latency.
- IO_WAIT, 0, wait cycles for LED/switch/counter accesses.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- breq_i  in  1  CPU bus request
- cpu_mio  in  1  CPU owns bus; requests are ignored when 0
- mem_w  in  1  1 = write, 0 = read (sampled with breq_i)
- addr_in  in  32  byte address from CPU
- data_from_cpu  in  32  write data
- data_to_cpu  out  32  read data register
- MIO_ready  out  1  transaction-complete pulse
- bus_err  out  1  unmapped-address pulse, coincident with MIO_ready
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  RAM_ADDR_W  word address, equal to addr_in[RAM_ADDR_W+1:2]
- ram_din  out  32  RAM write data
- ram_dout  in  32  RAM read data, valid the cycle after ram_en
- sw_in  in  8  asynchronous switches
- led_out  out  8  LED register

Behaviour:
- Reset (asynchronous, reset=0), effective immediately including mid-transaction:
  - FSM goes to IDLE.
  - MIO_ready, bus_err, ram_en, ram_we = 0.
  - data_to_cpu, led_out, counter, latched request registers = 0.
  - Switch synchronizer flops = 0.
  - An aborted transaction is never completed.
- Address map (decode on the latched address; low 2 bits ignored, word aligned):
  - addr[31:28]==4'h0 → RAM.
  - 32'hF000_0000 → read: {24'b0, synced sw_in}; write: led_out <= data[7:0].
  - 32'hF000_0004 → counter, read/write.
  - Anything else → unmapped: reads return 0, writes are dropped, bus_err=1 during DONE.
- FSM states: IDLE, ACCESS, WAIT, DONE.
  - IDLE: if breq_i & cpu_mio at a clock edge, latch addr, data, mem_w and region, then go to ACCESS. Otherwise stay.
  - ACCESS, exactly 1 cycle:
    - RAM: ram_en=1 and ram_we=latched mem_w; ram_addr/ram_din driven from the latched registers.
    - IO write: performed at the edge ending ACCESS.
    - IO read: value captured at the edge ending ACCESS only when IO_WAIT==0.
    - Load the wait counter with the region's WAIT (unmapped uses 0).
    - Next state: WAIT if the count > 0, else DONE.
  - WAIT: decrement once per cycle. At the edge ending the cycle where the count reaches 1, capture read data (ram_dout or the IO value) into data_to_cpu, then go to DONE.
  - DONE, exactly 1 cycle: MIO_ready=1, plus bus_err if unmapped. Return to IDLE; a new request can be accepted at the edge ending DONE only if it is presented in IDLE, so the earliest next ACCESS is 2 cycles after DONE.
- Latency: request sampled at edge E0 gives MIO_ready high in cycle W+2 after E0, with W the region wait.
  - Defaults: RAM = 3 cycles, IO = 2 cycles.
- data_to_cpu holds its value until the next read capture. Writes do not alter it.
- breq_i, addr_in and data_from_cpu are ignored after the latch. Deasserting breq_i mid-transaction does not abort it.
- The CPU must drop breq_i in the cycle after MIO_ready. Otherwise a second transaction starts.
- Counter:
  - Increments by 1 every clk and wraps from FFFF_FFFF to 0.
  - A CPU write in ACCESS loads data_from_cpu and takes priority over the increment that cycle.
  - A read returns the counter value during the ACCESS cycle.
- sw_in passes through a 2-flop synchronizer before being read.
- ram_en/ram_we are high only in ACCESS and are never asserted for IO or unmapped accesses.

Test Plan:
- RAM write then read: write 0xDEADBEEF to 0x0000_0010 → ram_we=1 with ram_addr=4 for 1 cycle, MIO_ready 3 cycles after request. Read 0x10 → data_to_cpu=0xDEADBEEF when MIO_ready=1.
- LED/switch: write 0x0000_00A5 to 0xF000_0000 → led_out=0xA5 after ACCESS, MIO_ready 2 cycles after request, no ram_en. Set sw_in=0x3C, wait 3 cycles, read → data_to_cpu=0x0000003C.
- Counter: write 0xFFFF_FFFE to 0xF000_0004, read 2 cycles later → 0x0000_0000 or later (wrap verified). Two back-to-back reads differ by exactly the inter-ACCESS spacing.
- Unmapped: read 0x8000_0000 → MIO_ready and bus_err high together for 1 cycle, data_to_cpu=0. A write to the same address changes no state.
- Reset mid-op: assert reset=0 during WAIT of a RAM read → MIO_ready never pulses, all outputs 0 immediately. After release, a new request completes normally.
- Gating/hold: breq_i=1 with cpu_mio=0 → no transaction. Hold breq_i high for 1 cycle after MIO_ready → exactly one additional transaction is issued.

Source files
------------

// File: rtl/mio_bus_responder.sv
// Target-side responder for the CPU memory/IO bus: decodes a latched request to
// block RAM, the LED/switch port or a free-running counter, then pulses MIO_ready.
module mio_bus_responder #(
  parameter int RAM_ADDR_W = 10,
  parameter int RAM_WAIT   = 1,
  parameter int IO_WAIT    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  breq_i,
  input  logic                  cpu_mio,
  input  logic                  mem_w,
  input  logic [31:0]           addr_in,
  input  logic [31:0]           data_from_cpu,
  output logic [31:0]           data_to_cpu,
  output logic                  MIO_ready,
  output logic                  bus_err,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout,
  input  logic [7:0]            sw_in,
  output logic [7:0]            led_out,
  output logic [1:0]            fsm_state
);

  // Handshake: a request is taken when breq_i & cpu_mio are high at an edge in
  // IDLE; completion is a single-cycle MIO_ready pulse (bus_err alongside it for
  // unmapped addresses). Inputs are not looked at again until the next IDLE.

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {R_RAM, R_SW, R_CNT, R_NONE} region_t;

  localparam logic [7:0] RAM_WAIT_C = 8'(RAM_WAIT);
  localparam logic [7:0] IO_WAIT_C  = 8'(IO_WAIT);

  state_t                state;
  region_t               region;
  region_t               dec_region;
  logic                  req_we;
  logic [RAM_ADDR_W-1:0] req_word;
  logic [31:0]           req_data;
  logic [7:0]            wait_cnt;
  logic [7:0]            region_wait;
  logic [31:0]           counter;
  logic [31:0]           io_rdata;
  logic [7:0]            sw_meta;
  logic [7:0]            sw_sync;

  // Low two address bits are masked so any byte of a word hits the same target.
  always_comb begin
    dec_region = R_NONE;
    if (addr_in[31:28] == 4'h0)
      dec_region = R_RAM;
    else if ((addr_in & 32'hFFFF_FFFC) == 32'hF000_0000)
      dec_region = R_SW;
    else if ((addr_in & 32'hFFFF_FFFC) == 32'hF000_0004)
      dec_region = R_CNT;
  end

  always_comb begin
    case (region)
      R_RAM:        region_wait = RAM_WAIT_C;
      R_SW, R_CNT:  region_wait = IO_WAIT_C;
      default:      region_wait = 8'd0;
    endcase
  end

  always_comb begin
    case (region)
      R_SW:    io_rdata = {24'b0, sw_sync};
      R_CNT:   io_rdata = counter;
      default: io_rdata = 32'd0;
    endcase
  end

  assign ram_addr  = req_word;
  assign ram_din   = req_data;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta <= 8'd0;
      sw_sync <= 8'd0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
    end
  end

  // A CPU write landing in ACCESS wins over that cycle's increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      counter <= 32'd0;
    else if (state == S_ACCESS && req_we && region == R_CNT)
      counter <= req_data;
    else
      counter <= counter + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      region      <= R_NONE;
      req_we      <= 1'b0;
      req_word    <= '0;
      req_data    <= 32'd0;
      wait_cnt    <= 8'd0;
      data_to_cpu <= 32'd0;
      led_out     <= 8'd0;
      MIO_ready   <= 1'b0;
      bus_err     <= 1'b0;
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
    end else begin
      MIO_ready <= 1'b0;
      bus_err   <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (breq_i && cpu_mio) begin
            region   <= dec_region;
            req_we   <= mem_w;
            req_word <= addr_in[RAM_ADDR_W+1:2];
            req_data <= data_from_cpu;
            state    <= S_ACCESS;
            if (dec_region == R_RAM) begin
              ram_en <= 1'b1;
              ram_we <= mem_w;
            end
          end
        end
        S_ACCESS: begin
          if (req_we && region == R_SW)
            led_out <= req_data[7:0];
          if (region_wait != 8'd0) begin
            wait_cnt <= region_wait;
            state    <= S_WAIT;
          end else begin
            if (!req_we)
              data_to_cpu <= io_rdata;
            MIO_ready <= 1'b1;
            bus_err   <= (region == R_NONE);
            state     <= S_DONE;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 8'd1) begin
            if (!req_we)
              data_to_cpu <= (region == R_RAM) ? ram_dout : io_rdata;
            MIO_ready <= 1'b1;
            bus_err   <= (region == R_NONE);
            state     <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
